dup_addsub_pipe: RTL and testbench

Parametrised, pipelined, self-checking add/subtract unit with duplicated datapath and two-rail error reporting. Accepts W-bit operands A and B with an even-parity bit and a 3-bit one-hot operation code. Computes A+B, A−B or B−A in two independent copies and emits both results with per-copy two-rail error codes. Sits between the operand source and the checker/voter stage of the dependable arithmetic path, adding valid/ready flow control and sticky error logging.

---
 rtl/dup_addsub_pipe_pkg.sv | 22 ++
 rtl/dup_addsub_pipe_if.sv | 36 +++
 rtl/dup_addsub_pipe_core.sv | 32 +++
 rtl/dup_addsub_pipe.sv | 172 +++++++++++++++++
 tb/tb_dup_addsub_pipe.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dup_addsub_pipe_pkg.sv
// Shared constants for the duplicated add/subtract path:
// op-code encodings, two-rail error codes and err_cause bit positions.
package dc_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_RSUB = 3'b100;

  localparam logic [1:0] TR_OK   = 2'b10;
  localparam logic [1:0] TR_ERR  = 2'b11;
  localparam logic [1:0] TR_NONE = 2'b00;

  localparam int ERR_PAR  = 0;
  localparam int ERR_CODE = 1;
  localparam int ERR_MIS  = 2;

  // Only the three one-hot codes are legal; anything else is a code error.
  function automatic logic op_legal(input logic [2:0] c);
    return (c == OP_ADD) || (c == OP_SUB) || (c == OP_RSUB);
  endfunction

endpackage

// File: rtl/dup_addsub_pipe_if.sv
// Operand/result bus of dup_addsub_pipe: operand beat with parity and
// op code in, duplicated results with two-rail error codes out.
interface dup_addsub_pipe_if #(
  parameter int W = 3
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         par;
  logic [2:0]   c;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         xc;
  logic         yc;
  logic [1:0]   xe;
  logic [1:0]   ye;
  logic [2:0]   err_cause;

  // Operand source / result sink side
  modport master (
    output in_valid, a, b, par, c, out_ready,
    input  in_ready, out_valid, x, y, xc, yc, xe, ye, err_cause
  );

  // Arithmetic unit side
  modport slave (
    input  in_valid, a, b, par, c, out_ready,
    output in_ready, out_valid, x, y, xc, yc, xe, ye, err_cause
  );

endinterface

// File: rtl/dup_addsub_pipe_core.sv
// dc_addsub_core: combinational negate-mux-add, one per datapath copy.
// A or B is two's-complement negated depending on the op code, then the
// selected operands are summed with a carry-out.
module dc_addsub_core
  import dc_alu_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   c_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] a_sel;
  logic [W-1:0] b_sel;
  logic [W:0]   sum;

  // Operand negation select followed by the W+1 bit add
  always_comb begin
    a_sel = (c_i[0] | c_i[1]) ? a_i : (~a_i + ONE);
    b_sel = (c_i[0] | c_i[2]) ? b_i : (~b_i + ONE);
    sum   = {1'b0, a_sel} + {1'b0, b_sel};
  end

  assign sum_o = sum[W-1:0];
  assign co_o  = sum[W];

endmodule

// File: rtl/dup_addsub_pipe.sv
// dup_addsub_pipe: two-stage elastic add/subtract pipeline with two
// independent datapath copies, parity/op-code/mismatch checking and
// two-rail error outputs. Sticky error status and the saturating error
// counter exist only when STICKY_ERR_EN is defined; otherwise they read 0.
module dup_addsub_pipe
  import dc_alu_pkg::*;
#(
  parameter int W     = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dup_addsub_pipe_if.slave   bus,
  input  logic [W-1:0]       inj_flip,
  input  logic               err_clr,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   err_cnt
);

  logic         s1_valid_q;
  logic [W-1:0] a_q, b_q;
  logic         par_q;
  logic [2:0]   c_q;

  logic         s2_valid_q;
  logic [W-1:0] x_q, y_q;
  logic         xc_q, yc_q;
  logic [1:0]   xe_q, ye_q;
  logic [2:0]   cause_q;

  logic [W-1:0] cx_sum, cy_sum;
  logic         cx_co, cy_co;
  logic [W-1:0] x_d, y_d;
  logic         xc_d, yc_d;
  logic [2:0]   cause_d;
  logic [1:0]   tr_d;
  logic         beat_err;

  logic s2_ready;
  logic s2_load;
  logic s1_accept;

  // S2 can take a new beat when empty or when its beat leaves this cycle;
  // that is exactly when S1 advances, so in_ready follows from it.
  assign s2_ready     = !s2_valid_q || bus.out_ready;
  assign s2_load      = s2_ready && s1_valid_q;
  assign bus.in_ready = !s1_valid_q || s2_ready;
  assign s1_accept    = bus.in_valid && bus.in_ready;

  // Stage 1: operand, parity and op-code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      par_q      <= 1'b0;
      c_q        <= '0;
    end else begin
      if (bus.in_ready) s1_valid_q <= bus.in_valid;
      if (s1_accept) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        par_q <= bus.par;
        c_q   <= bus.c;
      end
    end
  end

  dc_addsub_core #(.W(W)) u_copy_x (
    .a_i   (a_q),
    .b_i   (b_q),
    .c_i   (c_q),
    .sum_o (cx_sum),
    .co_o  (cx_co)
  );

  dc_addsub_core #(.W(W)) u_copy_y (
    .a_i   (a_q),
    .b_i   (b_q),
    .c_i   (c_q),
    .sum_o (cy_sum),
    .co_o  (cy_co)
  );

  // Error detection; an illegal code zeroes both copies so the compare
  // cannot also flag a mismatch from the injected flip.
  always_comb begin
    x_d  = cx_sum;
    xc_d = cx_co;
    y_d  = cy_sum ^ inj_flip;
    yc_d = cy_co;
    cause_d = '0;
    cause_d[ERR_PAR]  = ^{a_q, b_q, par_q};
    cause_d[ERR_CODE] = !op_legal(c_q);
    if (cause_d[ERR_CODE]) begin
      x_d  = '0;
      xc_d = 1'b0;
      y_d  = '0;
      yc_d = 1'b0;
    end
    cause_d[ERR_MIS] = ({x_d, xc_d} != {y_d, yc_d});
    beat_err = |cause_d;
    tr_d     = beat_err ? TR_ERR : TR_OK;
  end

  // Stage 2: both results and error flags, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      xc_q       <= 1'b0;
      yc_q       <= 1'b0;
      xe_q       <= TR_NONE;
      ye_q       <= TR_NONE;
      cause_q    <= '0;
    end else begin
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        x_q     <= x_d;
        y_q     <= y_d;
        xc_q    <= xc_d;
        yc_q    <= yc_d;
        xe_q    <= tr_d;
        ye_q    <= tr_d;
        cause_q <= cause_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.xc        = xc_q;
  assign bus.yc        = yc_q;
  assign bus.xe        = xe_q;
  assign bus.ye        = ye_q;
  assign bus.err_cause = cause_q;

`ifdef STICKY_ERR_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  // Sticky/counter update once per errored beat on its S2 load; a clear
  // coinciding with an errored beat leaves that beat counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else if (s2_load && beat_err) begin
      sticky_q <= 1'b1;
      if (err_clr)               cnt_q <= CNT_ONE;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
    end else if (err_clr) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end
  end

  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_sticky     = 1'b0;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_dup_addsub_pipe.sv
// Directed bench for dup_addsub_pipe at W=4. Sticky/counter expectations
// follow the STICKY_ERR_EN setting of the build.
module tb_dup_addsub_pipe;
  import dc_alu_pkg::*;

  localparam int W     = 4;
  localparam int CNT_W = 8;
`ifdef STICKY_ERR_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     inj_flip;
  logic             err_clr;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  dup_addsub_pipe_if #(.W(W)) bus ();

  dup_addsub_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .inj_flip   (inj_flip),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " out_valid"}, bus.out_valid, 0);
    chk({tag, " x"}, bus.x, 0);
    chk({tag, " y"}, bus.y, 0);
    chk({tag, " xc"}, bus.xc, 0);
    chk({tag, " yc"}, bus.yc, 0);
    chk({tag, " xe"}, bus.xe, 2'b00);
    chk({tag, " ye"}, bus.ye, 2'b00);
    chk({tag, " cause"}, bus.err_cause, 0);
    chk({tag, " sticky"}, err_sticky, 0);
    chk({tag, " cnt"}, err_cnt, 0);
  endtask

  // One isolated beat, called at posedge+1 with the pipeline empty.
  task automatic beat(input string tag,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic par, input logic [2:0] c,
                      input logic [3:0] flip, input logic clr,
                      input logic [3:0] ex, input logic [3:0] ey,
                      input logic exc, input logic eyc,
                      input logic [1:0] ee, input logic [2:0] ecause,
                      input logic estk, input int ecnt);
    bus.a = a; bus.b = b; bus.par = par; bus.c = c;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; inj_flip = flip;
    #3 chk({tag, " in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    err_clr = clr;
    chk({tag, " out_valid t+1"}, bus.out_valid, 0);
    @(posedge clk); #1;
    err_clr = 1'b0;
    inj_flip = '0;
    chk({tag, " out_valid t+2"}, bus.out_valid, 1);
    chk({tag, " x"}, bus.x, ex);
    chk({tag, " y"}, bus.y, ey);
    chk({tag, " xc"}, bus.xc, exc);
    chk({tag, " yc"}, bus.yc, eyc);
    chk({tag, " xe"}, bus.xe, ee);
    chk({tag, " ye"}, bus.ye, ee);
    chk({tag, " cause"}, bus.err_cause, ecause);
    chk({tag, " sticky"}, err_sticky, STK ? estk : 1'b0);
    chk({tag, " cnt"}, err_cnt, STK ? ecnt : 0);
    @(posedge clk); #1;
    chk({tag, " drained"}, bus.out_valid, 0);
  endtask

  logic [3:0] exp_x  [8] = '{4'h8, 4'hA, 4'hC, 4'hE, 4'h0, 4'h2, 4'h4, 4'h6};
  logic       exp_xc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int n_in, n_out, cyc;
    bit saw_full, prev_hold, in_hs, late_valid;
    logic [3:0] hx, hy;
    logic [1:0] hxe;
    logic [2:0] hcause;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.par = 1'b0; bus.c = '0;
    bus.out_ready = 1'b0; inj_flip = '0; err_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after reset", bus.in_ready, 1);
    chk("out_valid after reset", bus.out_valid, 0);

    //    tag      a     b     p     c       flip  clr   x     y     xc    yc    xe     cause   stk   cnt
    beat("add",   4'd3, 4'd5, 1'b0, 3'b001, 4'h0, 1'b0, 4'h8, 4'h8, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0, 0);
    beat("sub",   4'd3, 4'd5, 1'b0, 3'b010, 4'h0, 1'b0, 4'hE, 4'hE, 1'b0, 1'b0, 2'b10, 3'b000, 1'b0, 0);
    beat("rsub",  4'd3, 4'd5, 1'b0, 3'b100, 4'h0, 1'b0, 4'h2, 4'h2, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0, 0);
    beat("par",   4'd3, 4'd5, 1'b1, 3'b001, 4'h0, 1'b0, 4'h8, 4'h8, 1'b0, 1'b0, 2'b11, 3'b001, 1'b1, 1);
    beat("clean", 4'd1, 4'd2, 1'b0, 3'b001, 4'h0, 1'b0, 4'h3, 4'h3, 1'b0, 1'b0, 2'b10, 3'b000, 1'b1, 1);
    beat("c011",  4'd3, 4'd5, 1'b0, 3'b011, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b11, 3'b010, 1'b1, 2);
    beat("flip",  4'd3, 4'd5, 1'b0, 3'b001, 4'h1, 1'b0, 4'h8, 4'h9, 1'b0, 1'b0, 2'b11, 3'b100, 1'b1, 3);
    beat("c000",  4'd3, 4'd5, 1'b0, 3'b000, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b11, 3'b010, 1'b1, 4);
    beat("rsub0", 4'd5, 4'd5, 1'b0, 3'b100, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 2'b10, 3'b000, 1'b1, 4);
    beat("c110p", 4'd3, 4'd5, 1'b1, 3'b110, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b11, 3'b011, 1'b1, 5);

    // Back-to-back stream of 8 ADD beats a=b=i+4 with a 3-cycle stall
    n_in = 0; n_out = 0; cyc = 0; saw_full = 0; prev_hold = 0;
    hx = '0; hy = '0; hxe = '0; hcause = '0;
    while (n_out < 8 && cyc < 40) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 6);
      if (n_in < 8) begin
        bus.in_valid = 1'b1;
        bus.a = 4'(n_in + 4); bus.b = 4'(n_in + 4);
        bus.par = 1'b0; bus.c = OP_ADD;
      end else begin
        bus.in_valid = 1'b0;
      end
      #3;
      if (!bus.in_ready) saw_full = 1;
      if (prev_hold) begin
        chk("stall hold x", bus.x, hx);
        chk("stall hold y", bus.y, hy);
        chk("stall hold xe", bus.xe, hxe);
        chk("stall hold cause", bus.err_cause, hcause);
        chk("stall hold valid", bus.out_valid, 1);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      hx = bus.x; hy = bus.y; hxe = bus.xe; hcause = bus.err_cause;
      if (bus.out_valid && bus.out_ready) begin
        chk("stream x", bus.x, exp_x[n_out]);
        chk("stream y", bus.y, exp_x[n_out]);
        chk("stream xc", bus.xc, exp_xc[n_out]);
        chk("stream xe", bus.xe, 2'b10);
        n_out++;
      end
      in_hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (in_hs) n_in++;
      #1 cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream beats out", n_out, 8);
    chk("stream beats in", n_in, 8);
    chk("stream in_ready dropped", saw_full, 1);
    chk("stream within budget", (cyc < 40), 1);
    @(posedge clk); #1;
    chk("stream no extra beat", bus.out_valid, 0);

    // Reset with two beats in flight
    bus.a = 4'd1; bus.b = 4'd1; bus.par = 1'b0; bus.c = OP_ADD; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 4'd2; bus.b = 4'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pre-reset out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("async reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("in_ready after release", bus.in_ready, 1);
    late_valid = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.out_valid) late_valid = 1;
    end
    chk("flushed beats gone", late_valid, 0);
    @(posedge clk); #1;

    // Clear interacting with errored beats
    beat("par1",  4'd3, 4'd5, 1'b1, 3'b001, 4'h0, 1'b0, 4'h8, 4'h8, 1'b0, 1'b0, 2'b11, 3'b001, 1'b1, 1);
    beat("par2",  4'd3, 4'd5, 1'b1, 3'b001, 4'h0, 1'b0, 4'h8, 4'h8, 1'b0, 1'b0, 2'b11, 3'b001, 1'b1, 2);
    beat("parclr",4'd3, 4'd5, 1'b1, 3'b001, 4'h0, 1'b1, 4'h8, 4'h8, 1'b0, 1'b0, 2'b11, 3'b001, 1'b1, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr sticky", err_sticky, 0);
    chk("clr cnt", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
